// File: rtl/cdma_req_mux.sv
// Multi-channel DMA request front end: round-robin arbitration, chunk splitting
// and in-order completion routing back to the issuing channel.
module cdma_req_mux #(
  parameter int N_CHAN        = 4,
  parameter int ADDR_BITS     = 64,
  parameter int LEN_BITS      = 28,
  parameter int MAX_CHUNK     = 2**20,
  parameter int N_OUTSTANDING = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_CHAN-1:0]             s_req_valid,
  output logic [N_CHAN-1:0]             s_req_ready,
  input  logic [N_CHAN*ADDR_BITS-1:0]   s_req_addr,
  input  logic [N_CHAN*LEN_BITS-1:0]    s_req_len,
  input  logic [N_CHAN-1:0]             s_req_last,
  output logic [N_CHAN-1:0]             s_done,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [ADDR_BITS-1:0]          m_req_addr,
  output logic [LEN_BITS-1:0]           m_req_len,
  output logic                          m_req_last,
  input  logic                          m_done,
  output logic                          err_underflow
);

  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int PW = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;
  localparam int OW = $clog2(N_OUTSTANDING + 1);
  localparam int WW = LEN_BITS + 32;
  // Chunk limit held wider than the length field so any MAX_CHUNK compares safely.
  localparam logic [WW-1:0] MAX_W = WW'(MAX_CHUNK);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]           state;
  logic [CW-1:0]        rr_ptr;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [LEN_BITS-1:0]  rem;
  logic                 cur_last;
  logic [CW-1:0]        cur_ch;

  logic                 grant_found;
  logic [CW-1:0]        grant_ch;
  logic [CW:0]          cand;
  logic                 accept;
  logic                 is_final;
  logic [LEN_BITS-1:0]  chunk_len;
  logic                 push;
  logic                 pop;

  logic [CW:0]          fifo_mem [N_OUTSTANDING];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [OW-1:0]        count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW:0]          head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(N_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting one past the last served channel.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int i = 1; i <= N_CHAN; i++) begin
      cand = {1'b0, rr_ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(N_CHAN)) cand = cand - (CW+1)'(N_CHAN);
      if (!grant_found && s_req_valid[cand[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = cand[CW-1:0];
      end
    end
  end

  assign accept = (state == S_IDLE) && grant_found;

  always_comb begin
    s_req_ready = '0;
    if (accept && !areset) s_req_ready[grant_ch] = 1'b1;
  end

  assign is_final   = ({32'b0, rem} <= MAX_W);
  assign chunk_len  = is_final ? rem : MAX_W[LEN_BITS-1:0];

  assign fifo_full  = (count == OW'(N_OUTSTANDING));
  assign fifo_empty = (count == '0);

  assign m_req_valid = (state == S_ISSUE) && !fifo_full;
  assign m_req_addr  = cur_addr;
  assign m_req_len   = chunk_len;
  assign m_req_last  = 1'b1;

  assign push = m_req_valid && m_req_ready;
  assign pop  = m_done && !fifo_empty;
  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (areset) begin
      state    <= S_IDLE;
      rr_ptr   <= CW'(N_CHAN - 1);
      cur_addr <= '0;
      rem      <= '0;
      cur_last <= 1'b0;
      cur_ch   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_addr <= s_req_addr[grant_ch*ADDR_BITS +: ADDR_BITS];
            rem      <= s_req_len[grant_ch*LEN_BITS +: LEN_BITS];
            cur_last <= s_req_last[grant_ch];
            cur_ch   <= grant_ch;
            state    <= S_ISSUE;
          end
        end
        default: begin
          if (push) begin
            if (is_final) begin
              rr_ptr <= cur_ch;
              state  <= S_IDLE;
            end else begin
              cur_addr <= cur_addr + ADDR_BITS'(chunk_len);
              rem      <= rem - chunk_len;
            end
          end
        end
      endcase
    end
  end

  // NOTE: the tracking storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= {cur_ch, is_final && cur_last};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_done        <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Only final chunks of last=1 requests carry a set flag.
      s_done <= '0;
      if (pop && head[0]) s_done[head[CW:1]] <= 1'b1;
      if (m_done && fifo_empty) err_underflow <= 1'b1;
    end
  end

endmodule
